// File: rtl/bsg_gateway_channel_pkg.sv
// Shared widths and defaults for gateway link channels, used by both the
// receive endpoint and the transmit-side credit counters.
package bsg_gateway_channel_pkg;

  localparam int channel_width_gp             = 8;
  localparam int channel_credits_gp           = 16;
  localparam int channel_credit_decimation_gp = 4;

  localparam int channel_ptr_width_gp   = $clog2(channel_credits_gp);
  localparam int channel_count_width_gp = $clog2(channel_credits_gp + 1);
  localparam int channel_dec_width_gp   = (channel_credit_decimation_gp > 1)
                                          ? $clog2(channel_credit_decimation_gp) : 1;

endpackage

// File: rtl/bsg_gateway_token_gen.sv
// Credit-return generator: toggles token_o once per credit_decimation_p dequeues.
module bsg_gateway_token_gen
  import bsg_gateway_channel_pkg::*;
#(
  parameter int credit_decimation_p = channel_credit_decimation_gp
) (
  input  logic clk_i,
  input  logic async_reset_n_i,
  input  logic deq_i,
  output logic token_o
);

  localparam int lg_dec_lp = (credit_decimation_p > 1) ? $clog2(credit_decimation_p) : 1;
  localparam logic [lg_dec_lp-1:0] last_lp = lg_dec_lp'(credit_decimation_p - 1);

  logic [lg_dec_lp-1:0] r_cnt;
  logic                 r_token;
  logic                 w_wrap;

  assign w_wrap = deq_i & (r_cnt == last_lp);

  // Partial groups stay in r_cnt; they are only discarded by reset.
  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      r_cnt   <= '0;
      r_token <= 1'b0;
    end else if (deq_i) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) r_token <= ~r_token;
    end
  end

  assign token_o = r_token;

endmodule

// File: rtl/bsg_gateway_channel_rx.sv
// Receive endpoint of a gateway link channel: input register, circular FIFO
// with valid/yumi head interface, and decimated token credit return.
module bsg_gateway_channel_rx
  import bsg_gateway_channel_pkg::*;
#(
  parameter int channel_width_p     = channel_width_gp,
  parameter int els_p               = channel_credits_gp,
  parameter int credit_decimation_p = channel_credit_decimation_gp
) (
  input  logic                         clk_i,
  input  logic                         async_reset_n_i,
  input  logic                         valid_i,
  input  logic [channel_width_p-1:0]   data_i,
  output logic                         token_o,
  output logic                         v_o,
  output logic [channel_width_p-1:0]   data_o,
  input  logic                         yumi_i,
  output logic [$clog2(els_p+1)-1:0]   count_o,
  output logic                         overflow_o
);

  localparam int lg_els_lp = $clog2(els_p);
  localparam int cnt_w_lp  = $clog2(els_p + 1);
  localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(els_p);

  logic                       r_valid;
  logic [channel_width_p-1:0] r_data;
  logic [lg_els_lp-1:0]       r_wr_ptr;
  logic [lg_els_lp-1:0]       r_rd_ptr;
  logic [cnt_w_lp-1:0]        r_count;
  logic                       r_overflow;
  logic [channel_width_p-1:0] r_mem [els_p];

  logic                w_deq;
  logic                w_enq;
  logic                w_full;
  logic [cnt_w_lp-1:0] w_count_next;

  assign v_o    = (r_count != '0);
  assign w_full = (r_count == full_lp);
  assign w_deq  = yumi_i & v_o;
  // A full FIFO still accepts the beat when the head leaves on the same edge.
  assign w_enq  = r_valid & (~w_full | w_deq);

  always_comb begin
    w_count_next = r_count;
    if (w_enq & ~w_deq)      w_count_next = r_count + 1'b1;
    else if (~w_enq & w_deq) w_count_next = r_count - 1'b1;
  end

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= valid_i;
      r_data  <= data_i;
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      if (r_valid & ~w_enq) r_overflow <= 1'b1;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wr_ptr] <= r_data;
  end

  assign data_o     = r_mem[r_rd_ptr];
  assign count_o    = r_count;
  assign overflow_o = r_overflow;

  bsg_gateway_token_gen #(
    .credit_decimation_p(credit_decimation_p)
  ) u_token_gen (
    .clk_i          (clk_i),
    .async_reset_n_i(async_reset_n_i),
    .deq_i          (w_deq),
    .token_o        (token_o)
  );

endmodule

// File: tb/tb_bsg_gateway_channel_rx.sv
// Directed + random bench for bsg_gateway_channel_rx with a reference queue
// model of the FIFO, overflow flag and token decimation.
module tb_bsg_gateway_channel_rx;
  import bsg_gateway_channel_pkg::*;

  localparam int ELS = channel_credits_gp;
  localparam int DEC = channel_credit_decimation_gp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid_i = 1'b0;
  logic [7:0] data_i = '0;
  logic       yumi_i = 1'b0;
  logic       token_o, v_o, overflow_o;
  logic [7:0] data_o;
  logic [channel_count_width_gp-1:0] count_o;

  bsg_gateway_channel_rx dut (
    .clk_i          (clk),
    .async_reset_n_i(rst_n),
    .valid_i        (valid_i),
    .data_i         (data_i),
    .token_o        (token_o),
    .v_o            (v_o),
    .data_o         (data_o),
    .yumi_i         (yumi_i),
    .count_o        (count_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] sbq[$];
  int         m_count = 0;
  bit         m_vr = 0;
  logic [7:0] m_dr = '0;
  bit         m_ovf = 0;
  bit         m_tok = 0;
  int         m_tcnt = 0;
  int         toggles = 0;
  logic       prev_tok = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare at negedge, advance the model.
  task automatic cyc(input bit v, input logic [7:0] d, input bit y);
    bit deq, enq;
    logic [7:0] e;
    valid_i = v; data_i = d; yumi_i = y;
    @(negedge clk);
    chk("v_o", {31'd0, v_o}, {31'd0, m_count > 0});
    chk("count_o", 32'(count_o), 32'(m_count));
    chk("token_o", {31'd0, token_o}, {31'd0, m_tok});
    chk("overflow_o", {31'd0, overflow_o}, {31'd0, m_ovf});
    deq = y && (m_count > 0);
    if (deq) begin
      e = sbq.pop_front();
      chk("data_o", 32'(data_o), 32'(e));
    end
    enq = m_vr && ((m_count < ELS) || deq);
    if (enq) sbq.push_back(m_dr);
    else if (m_vr) m_ovf = 1;
    m_count += int'(enq) - int'(deq);
    if (deq) begin
      if (m_tcnt == DEC - 1) begin m_tcnt = 0; m_tok = ~m_tok; end
      else m_tcnt++;
    end
    m_vr = v; m_dr = d;
    if (token_o !== prev_tok) toggles++;
    prev_tok = token_o;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0; valid_i = 1'b0; yumi_i = 1'b0;
    #1;
    chk("rst_v_o", {31'd0, v_o}, 32'd0);
    chk("rst_count_o", 32'(count_o), 32'd0);
    chk("rst_token_o", {31'd0, token_o}, 32'd0);
    chk("rst_overflow_o", {31'd0, overflow_o}, 32'd0);
    sbq.delete();
    m_count = 0; m_vr = 0; m_ovf = 0; m_tok = 0; m_tcnt = 0; prev_tok = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_count > 0 || m_vr) && n < 64) begin
      cyc(1'b0, 8'h00, 1'b1);
      n++;
    end
    chk("drain_count_o", 32'(count_o), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // single beat
    cyc(1'b1, 8'hA5, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("single_v", {31'd0, v_o}, 32'd1);
    chk("single_data", 32'(data_o), 32'hA5);
    chk("single_count", 32'(count_o), 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("single_v_after", {31'd0, v_o}, 32'd0);
    chk("single_count_after", 32'(count_o), 32'd0);
    chk("single_token", {31'd0, token_o}, 32'd0);

    // fill to full, then overflow with one dropped beat
    for (int i = 0; i < ELS; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("fill_count", 32'(count_o), 32'd16);
    chk("fill_ovf", {31'd0, overflow_o}, 32'd0);
    cyc(1'b1, 8'hFF, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovf_set", {31'd0, overflow_o}, 32'd1);
    chk("ovf_count", 32'(count_o), 32'd16);
    drain();
    chk("ovf_sticky", {31'd0, overflow_o}, 32'd1);

    // full with simultaneous enqueue and dequeue
    do_reset();
    for (int i = 0; i < ELS; i++) cyc(1'b1, 8'(i + 8'h10), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("full_enqdeq_count", 32'(count_o), 32'd16);
    chk("full_enqdeq_ovf", {31'd0, overflow_o}, 32'd0);
    drain();

    // token decimation
    do_reset();
    toggles = 0;
    for (int i = 0; i < 12; i++) cyc(1'b1, 8'(i + 8'h20), 1'b1);
    drain();
    cyc(1'b0, 8'h00, 1'b0);
    chk("token_toggles", 32'(toggles), 32'd3);
    chk("token_final", {31'd0, token_o}, 32'd1);

    // random traffic with stalls
    do_reset();
    begin
      int sent = 0;
      int guard = 0;
      while (sent < 100 && guard < 2000) begin
        bit v, y;
        v = bit'($urandom_range(0, 1));
        y = ($urandom_range(0, 9) < 7);
        if (v) sent++;
        cyc(v, 8'($urandom), y);
        guard++;
      end
      chk("rand_sent", 32'(sent), 32'd100);
    end
    drain();

    // reset in the middle of a partial credit group
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(i + 8'h60), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("mid_count", 32'(count_o), 32'd6);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i + 8'h70), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("mid_no_toggle", {31'd0, token_o}, 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("mid_first_toggle", {31'd0, token_o}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
